// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: scans B two bits per cycle through an external
// Booth encoder and accumulates the shifted partial products into a signed product.
//
// state | meaning
// IDLE  | ready for operands, in_ready high
// RUN   | one Booth digit per cycle, triplet driven to the encoder
// DONE  | product held on out_p until the consumer takes it
module booth_seq_multiplier #(
   parameter int A_WIDTH = 24,
   parameter int B_WIDTH = 8,
   parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] in_a,
   input  logic [B_WIDTH-1:0] in_b,
   output logic [2:0]         booth_enc_in,
   input  logic               booth_enc_neg,
   input  logic               booth_enc_A,
   input  logic               booth_enc_2A,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] out_p
);

   localparam int NSTEPS = B_WIDTH / 2;
   localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [A_WIDTH-1:0] a_reg;
   logic [B_WIDTH-1:0] b_reg;
   logic [P_WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic [CNT_W:0]     sh;
   logic [B_WIDTH:0]   b_ext;
   logic [P_WIDTH-1:0] a_ext;
   logic [P_WIDTH-1:0] mag;
   logic [P_WIDTH-1:0] pp;
   logic [P_WIDTH-1:0] acc_next;

   assign sh    = {cnt, 1'b0};
   assign b_ext = {b_reg, 1'b0};
   assign a_ext = {{(P_WIDTH - A_WIDTH){a_reg[A_WIDTH-1]}}, a_reg};

   // Triplet comes purely from registered B and counter, so no input-to-encoder path.
   assign booth_enc_in = (state == RUN) ? b_ext[sh +: 3] : 3'b000;

   always_comb begin
      mag = '0;
      if (booth_enc_2A)
         mag = a_ext << 1;
      else if (booth_enc_A)
         mag = a_ext;
      pp       = booth_enc_neg ? (~mag + 1'b1) : mag;
      acc_next = acc + (pp << sh);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_p     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_p     <= acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier with a behavioural radix-4 Booth encoder
// and a queue of expected products.
module tb_booth_seq_multiplier;

   localparam int AW = 24;
   localparam int BW = 8;
   localparam int PW = AW + BW;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [AW-1:0] in_a;
   logic signed [BW-1:0] in_b;
   logic [2:0]           booth_enc_in;
   logic                 enc_neg, enc_a, enc_2a;
   logic                 out_valid;
   logic                 out_ready;
   logic [PW-1:0]        out_p;

   int n_vec = 0;
   int n_err = 0;
   logic signed [PW-1:0] exp_q[$];

   always #5 clk = ~clk;

   booth_seq_multiplier #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .booth_enc_in(booth_enc_in), .booth_enc_neg(enc_neg),
      .booth_enc_A(enc_a), .booth_enc_2A(enc_2a),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
   );

   // Standard radix-4 Booth digit table: 000/111 -> 0, 001/010 -> +A, 011 -> +2A,
   // 100 -> -2A, 101/110 -> -A.
   always_comb begin
      enc_neg = booth_enc_in[2];
      enc_a   = booth_enc_in[1] ^ booth_enc_in[0];
      enc_2a  = (booth_enc_in == 3'b011) || (booth_enc_in == 3'b100);
   end

   function automatic logic [11:0] exp_trips(input logic [BW-1:0] b);
      logic [BW:0]  bx;
      logic [11:0]  r;
      bx = {b, 1'b0};
      r  = '0;
      for (int i = 0; i < 4; i++) r[3*i +: 3] = bx[2*i +: 3];
      return r;
   endfunction

   task automatic issue(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                        output bit ok);
      int guard;
      logic signed [PW-1:0] e;
      guard = 0;
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      ok = in_ready;
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
         in_valid = 1'b0;
         return;
      end
      e = a * b;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called right after the accept edge; records the triplet seen in each RUN cycle.
   task automatic wait_out(output logic [PW-1:0] p, output int lat, output logic [11:0] trips,
                           output bit ok);
      lat = 0; trips = '0; ok = 1'b0;
      while (lat < 40) begin
         if (lat < 4) trips[3*lat +: 3] = booth_enc_in;
         @(posedge clk); #1;
         lat++;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      p = out_p;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
      n_vec++; if (out_p !== '0) begin n_err++; $display("FAIL reset_out_p: got %h need 0", out_p); end
      n_vec++; if (booth_enc_in !== 3'b000) begin n_err++; $display("FAIL reset_enc_in: got %b need 000", booth_enc_in); end
      rst_n = 1'b1;
   endtask

   task automatic test_products();
      logic signed [AW-1:0] va [10];
      logic signed [BW-1:0] vb [10];
      logic [PW-1:0] p;
      logic [11:0]   tr;
      logic signed [PW-1:0] e;
      int lat;
      bit ok;
      va[0] = 24'sd1000;     vb[0] = 8'sd100;
      va[1] = -24'sd1;       vb[1] = -8'sd1;
      va[2] = 24'sd12345;    vb[2] = 8'sd0;
      va[3] = -24'sd8388608; vb[3] = -8'sd128;
      va[4] = 24'sd8388607;  vb[4] = 8'sd127;
      va[5] = -24'sd8388608; vb[5] = 8'sd127;
      for (int i = 6; i < 10; i++) begin
         va[i] = AW'($urandom);
         vb[i] = BW'($urandom);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         issue(va[i], vb[i], ok);
         if (!ok) continue;
         wait_out(p, lat, tr, ok);
         e = exp_q.pop_front();
         n_vec++;
         if (!ok) begin
            n_err++; $display("FAIL prod_timeout[%0d]: out_valid=%b, required 1", i, out_valid);
            continue;
         end
         n_vec++; if (lat != 4) begin n_err++; $display("FAIL latency[%0d]: got %0d edges need 4", i, lat); end
         if (p !== e) begin n_err++; $display("FAIL product[%0d]: A=%0d B=%0d got %0d need %0d", i, va[i], vb[i], $signed(p), e); end
         n_vec++; if (tr !== exp_trips(vb[i])) begin n_err++; $display("FAIL triplets[%0d]: got %h need %h", i, tr, exp_trips(vb[i])); end
         n_vec++; if (booth_enc_in !== 3'b000) begin n_err++; $display("FAIL done_enc_in[%0d]: got %b need 000", i, booth_enc_in); end
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL handshake[%0d]: out_valid=%b in_ready=%b, required 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] p;
      logic [11:0]   tr;
      logic signed [PW-1:0] e;
      int lat;
      bit ok;
      out_ready = 1'b0;
      issue(-24'sd7000, 8'sd113, ok);
      if (!ok) return;
      in_a = 24'sd999; in_b = 8'sd3; in_valid = 1'b1;
      wait_out(p, lat, tr, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || p !== e || lat != 4) begin
         n_err++; $display("FAIL bp_product: got %0d lat %0d, need %0d lat 4", $signed(p), lat, e);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || out_p !== e || in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_hold[%0d]: out_valid=%b out_p=%0d in_ready=%b, need 1/%0d/0", c, out_valid, $signed(out_p), in_ready, e);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
      end
      repeat (6) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_no_capture: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc [2];
      int n_acc, got;
      bit pending;
      logic signed [PW-1:0] e;
      n_acc = 0; got = 0; pending = 1'b0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      out_ready = 1'b1;
      @(negedge clk);
      in_a = 24'sd4660; in_b = -8'sd77; in_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 2; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (pending) begin
            if (n_acc == 1) begin in_a = -24'sd123456; in_b = 8'sd45; end
            else in_valid = 1'b0;
            pending = 1'b0;
         end
         if (out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (out_p !== e) begin n_err++; $display("FAIL b2b_product[%0d]: got %0d need %0d", got, $signed(out_p), e); end
            got++;
         end
         if (in_valid && in_ready) begin
            e = in_a * in_b;
            exp_q.push_back(e);
            if (n_acc < 2) acc_cyc[n_acc] = cyc;
            n_acc++;
            pending = 1'b1;
         end
      end
      in_valid = 1'b0;
      n_vec++;
      if (got != 2 || n_acc != 2 || acc_cyc[1] - acc_cyc[0] != 6) begin
         n_err++; $display("FAIL b2b_sequence: outputs=%0d accepts=%0d interval=%0d, need 2/2/6", got, n_acc, acc_cyc[1] - acc_cyc[0]);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_run();
      logic [PW-1:0] p;
      logic [11:0]   tr;
      logic signed [PW-1:0] e;
      int lat;
      bit ok, saw_valid;
      out_ready = 1'b1;
      issue(24'sd100, 8'sd100, ok);
      if (!ok) return;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0 || booth_enc_in !== 3'b000) begin
         n_err++; $display("FAIL async_reset: in_ready=%b out_valid=%b out_p=%h enc=%b, need 1/0/0/000", in_ready, out_valid, out_p, booth_enc_in);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid) saw_valid = 1'b1;
      end
      n_vec++;
      if (saw_valid) begin n_err++; $display("FAIL reset_discard: out_valid pulse seen, need none"); end
      issue(24'sd3, -8'sd5, ok);
      if (!ok) return;
      wait_out(p, lat, tr, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || p !== e || lat != 4) begin
         n_err++; $display("FAIL post_reset_product: got %0d lat %0d, need %0d lat 4", $signed(p), lat, e);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; rst_n = 1'b0;
      test_reset();
      test_products();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
Sequential radix-4 Booth multiplier control and accumulation stage. It wraps the existing combinational Booth encoder in a loop.
- Upstream role: scans the signed multiplier B two bits per cycle and drives the 3-bit triplet into the encoder.
- Downstream role: consumes the encoder's neg/A/2A selects, builds each partial product from multiplicand A, and accumulates the signed product.
- Sits between the operand-issue logic and the result consumer, with valid/ready handshakes on both sides.

Parameters:
A_WIDTH, 24, multiplicand width, signed two's complement.
B_WIDTH, 8, multiplier width, signed two's complement; must be even and >= 2.
P_WIDTH, A_WIDTH+B_WIDTH, product width. Derived; do not override.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  block can accept operands.
in_a  input  A_WIDTH  multiplicand, signed.
in_b  input  B_WIDTH  multiplier, signed.
booth_enc_in  output  3  current Booth triplet, to the encoder.
booth_enc_neg  input  1  from encoder: negate partial product.
booth_enc_A  input  1  from encoder: select 1×A.
booth_enc_2A  input  1  from encoder: select 2×A.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
out_p  output  P_WIDTH  signed product A×B.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, in_ready=1, out_valid=0, out_p=0.
  - Step counter=0; A/B registers and accumulator=0; booth_enc_in=3'b000.
- States: IDLE, RUN, DONE. NSTEPS = B_WIDTH/2 (4 at default).
- IDLE: in_ready=1.
  - On in_valid&&in_ready edge: latch in_a, in_b; acc=0; cnt=0; go to RUN. in_ready drops the next cycle.
- RUN: in_ready=0, out_valid=0.
  - booth_enc_in = {B[2cnt+1], B[2cnt], B[2cnt-1]}, with B[-1]=0. Driven from registered state only, no combinational path from inputs.
  - Encoder selects are combinational inputs used in the same cycle.
  - mag = 2A if booth_enc_2A; else A if booth_enc_A; else 0. 2A wins if both are asserted.
  - A is sign-extended to P_WIDTH before shifting.
  - pp = neg ? -mag : mag. If mag=0, pp=0 regardless of neg.
  - Each edge: acc += pp << (2·cnt), modulo 2^P_WIDTH; cnt++.
  - On the edge where cnt==NSTEPS-1: out_p<=final acc, out_valid<=1, go to DONE.
- DONE: out_valid=1, out_p stable, in_ready=0, booth_enc_in=3'b000.
  - On out_valid&&out_ready edge: out_valid<=0, go to IDLE; in_ready=1 the next cycle.
  - out_ready low: hold indefinitely with no change to out_p.
- booth_enc_in=3'b000 whenever the state is not RUN.
- Latency: out_valid rises NSTEPS edges after the accept edge (4 at default). Minimum issue interval is NSTEPS+2 cycles. No overlap, no input buffering.
- in_valid with in_ready low: ignored. Operands are not captured.
- Async reset mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded and no out_valid pulse occurs.
- Result is exact for all signed operand pairs; no overflow at P_WIDTH. Most-negative × most-negative is representable.

Test Plan:
- A=1000, B=100 (default params, with booth_encoder connected) -> out_p=100000; out_valid rises exactly 4 edges after accept.
- A=-1 (0xFFFFFF), B=-1 (0xFF) -> out_p=1. Also A=12345, B=0 -> out_p=0, booth_enc_in 000 every RUN cycle.
- A=-8388608, B=-128 -> out_p=0x40000000. A=8388607, B=127 -> out_p=1065353089. A=-8388608, B=127 -> out_p=-1065353216.
- Backpressure: out_ready held low 10 cycles after out_valid -> out_valid and out_p stable throughout. in_valid pulses during RUN/DONE are not captured. Completes one cycle after out_ready=1.
- Back-to-back: in_valid held high with two operand sets -> second accepted only after first handshake; both products correct, in order.
- rst_n asserted during the 2nd RUN cycle -> all outputs at reset values asynchronously. A subsequent operation (A=3, B=-5 -> -15) is correct.
